// File: rtl/down_counter_2bit_pkg.sv
// Shared constants for the 2-bit down counter.
// Width and default reset value live here.
package down_counter_2bit_pkg;
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_RST = 2'b11;
endpackage

// File: rtl/down_counter_2bit_cells.sv
// Gate primitives and the storage element used by the counter.
// dff_sr: rising-edge D flop, synchronous active-high reset to rv_i.
module nandgate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = ~(a_i & b_i);
endmodule

module notgate (
    input  logic a_i,
    output logic y_o
);
    assign y_o = ~a_i;
endmodule

module dff_sr (
    input  logic clk,
    input  logic rst_i,
    input  logic rv_i,
    input  logic d_i,
    output logic q_o,
    output logic qb_o
);
    logic q_q;
    logic q_d;

    assign q_d = rst_i ? rv_i : d_i;

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q_o  = q_q;
    assign qb_o = ~q_q;
endmodule

// File: rtl/down_counter_2bit.sv
// 2-bit loadable down counter with borrow-out and wrap pulse,
// built from nand/not gates around three dff_sr flops.
module down_counter_2bit
    import down_counter_2bit_pkg::*;
#(
    parameter logic [CNT_W-1:0] RESET_VAL = CNT_RST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] d,
    output logic [CNT_W-1:0] q,
    output logic [CNT_W-1:0] qb,
    output logic             zero,
    output logic             bo,
    output logic             wrap
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_qb;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] dec;
    logic [CNT_W-1:0] cnt_e;
    logic             en_n, load_n;
    logic             x_n, x_a, x_b, x_o;
    logic [CNT_W-1:0] me_a, me_b;
    logic [CNT_W-1:0] ml_a, ml_b;
    logic             z_n, ez_n, ez, bo_n;
    logic             wrap_q, wrap_qb, wrap_qbn, wrap_n;

    notgate u_en_n   (.a_i(en),   .y_o(en_n));
    notgate u_load_n (.a_i(load), .y_o(load_n));

    // Decrement: bit0 toggles, bit1 = q1 xnor q0
    assign dec[0] = cnt_qb[0];
    nandgate u_x0 (.a_i(cnt_q[1]), .b_i(cnt_q[0]), .y_o(x_n));
    nandgate u_x1 (.a_i(cnt_q[1]), .b_i(x_n),      .y_o(x_a));
    nandgate u_x2 (.a_i(cnt_q[0]), .b_i(x_n),      .y_o(x_b));
    nandgate u_x3 (.a_i(x_a),      .b_i(x_b),      .y_o(x_o));
    notgate  u_x4 (.a_i(x_o),      .y_o(dec[1]));

    for (genvar i = 0; i < CNT_W; i++) begin : g_bit
        nandgate u_me0 (.a_i(cnt_q[i]), .b_i(en_n),   .y_o(me_a[i]));
        nandgate u_me1 (.a_i(dec[i]),   .b_i(en),     .y_o(me_b[i]));
        nandgate u_me2 (.a_i(me_a[i]),  .b_i(me_b[i]), .y_o(cnt_e[i]));

        nandgate u_ml0 (.a_i(cnt_e[i]), .b_i(load_n), .y_o(ml_a[i]));
        nandgate u_ml1 (.a_i(d[i]),     .b_i(load),   .y_o(ml_b[i]));
        nandgate u_ml2 (.a_i(ml_a[i]),  .b_i(ml_b[i]), .y_o(cnt_d[i]));

        dff_sr u_ff (
            .clk  (clk),
            .rst_i(rst),
            .rv_i (RESET_VAL[i]),
            .d_i  (cnt_d[i]),
            .q_o  (cnt_q[i]),
            .qb_o (cnt_qb[i])
        );
    end

    nandgate u_z0  (.a_i(cnt_qb[1]), .b_i(cnt_qb[0]), .y_o(z_n));
    notgate  u_z1  (.a_i(z_n),       .y_o(zero));
    nandgate u_b0  (.a_i(en),        .b_i(zero),      .y_o(ez_n));
    notgate  u_b1  (.a_i(ez_n),      .y_o(ez));
    nandgate u_b2  (.a_i(ez),        .b_i(load_n),    .y_o(bo_n));
    notgate  u_b3  (.a_i(bo_n),      .y_o(bo));

    // A borrow-out edge is exactly a 0->3 decrement, so bo feeds wrap
    dff_sr u_wrap (
        .clk  (clk),
        .rst_i(rst),
        .rv_i (1'b0),
        .d_i  (bo),
        .q_o  (wrap_q),
        .qb_o (wrap_qb)
    );

    notgate  u_w0 (.a_i(wrap_qb), .y_o(wrap_qbn));
    nandgate u_w1 (.a_i(wrap_q),  .b_i(wrap_qbn), .y_o(wrap_n));
    notgate  u_w2 (.a_i(wrap_n),  .y_o(wrap));

    assign q  = cnt_q;
    assign qb = cnt_qb;
endmodule

// File: tb/tb_down_counter_2bit.sv
// Self-checking bench: directed and random steps against an
// arithmetic model, plus a two-stage cascade check.
module tb_down_counter_2bit;
    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b0, load = 1'b0;
    logic [1:0] d = 2'b00;
    logic [1:0] q, qb;
    logic       zero, bo, wrap;

    logic       c_rst = 1'b0, c_en = 1'b0;
    logic [1:0] lq, lqb, hq, hqb;
    logic       lzero, lbo, lwrap, hzero, hbo, hwrap;

    int vectors = 0;
    int miscompares = 0;

    int m_q = 0;
    int m_wrap = 0;
    bit m_ok = 1'b0;

    always #5 clk = ~clk;

    down_counter_2bit dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .d(d),
        .q(q), .qb(qb), .zero(zero), .bo(bo), .wrap(wrap)
    );

    down_counter_2bit u_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .load(1'b0), .d(2'b00),
        .q(lq), .qb(lqb), .zero(lzero), .bo(lbo), .wrap(lwrap)
    );

    down_counter_2bit u_hi (
        .clk(clk), .rst(c_rst), .en(lbo), .load(1'b0), .d(2'b00),
        .q(hq), .qb(hqb), .zero(hzero), .bo(hbo), .wrap(hwrap)
    );

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic l,
                        input logic e, input logic [1:0] dv);
        @(negedge clk);
        rst = r; load = l; en = e; d = dv;
        #1;
        if (m_ok) begin
            chk("zero", {3'b0, zero}, {3'b0, m_q == 0});
            chk("bo", {3'b0, bo}, {3'b0, e && !l && m_q == 0});
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_q = 3; m_wrap = 0;
        end else if (l) begin
            m_q = dv; m_wrap = 0;
        end else if (e) begin
            m_wrap = (m_q == 0) ? 1 : 0;
            m_q = (m_q + 3) % 4;
        end else begin
            m_wrap = 0;
        end
        m_ok = 1'b1;
        chk("q", {2'b0, q}, m_q[3:0]);
        chk("qb", {2'b0, qb}, {2'b0, ~m_q[1:0]});
        chk("wrap", {3'b0, wrap}, m_wrap[3:0]);
    endtask

    initial begin
        int wraps;
        int exp_c;

        step(1, 0, 0, 2'b00);
        chk("rst_zero", {3'b0, zero}, 4'd0);

        step(0, 0, 1, 2'b00);
        step(0, 0, 1, 2'b00);
        step(0, 0, 1, 2'b00);
        step(0, 0, 1, 2'b00);
        step(0, 0, 1, 2'b00);

        step(0, 1, 1, 2'b00);
        step(0, 1, 0, 2'b11);
        step(0, 0, 1, 2'b00);

        step(0, 1, 0, 2'b10);
        step(0, 0, 1, 2'b00);
        step(1, 1, 1, 2'b00);

        step(0, 1, 0, 2'b01);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 2'b10);
        step(0, 1, 1, 2'b11);
        step(0, 1, 0, 2'b00);
        step(0, 1, 0, 2'b11);

        for (int i = 0; i < 300; i++) begin
            logic r, l, e;
            logic [1:0] dv;
            r  = ($urandom_range(0, 15) == 0);
            l  = ($urandom_range(0, 4) == 0);
            e  = ($urandom_range(0, 3) != 0);
            dv = 2'($urandom_range(0, 3));
            step(r, l, e, dv);
        end

        @(negedge clk);
        c_rst = 1'b1; c_en = 1'b0;
        @(posedge clk); #1;
        chk("casc_rst", {hq, lq}, 4'd15);
        @(negedge clk);
        c_rst = 1'b0; c_en = 1'b1;
        wraps = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            exp_c = (15 - k + 16) % 16;
            chk("casc_cnt", {hq, lq}, exp_c[3:0]);
            if (hwrap) wraps++;
        end
        chk("casc_wraps", 4'(wraps), 4'd1);
        @(negedge clk);
        c_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
